// File: rtl/wb_write_arbiter.sv
// Register-file write master: merges pipeline writeback with buffered long-latency results.
// Latency: 1 cycle from an accepted source to we/waddr/wdata (registered write port).
// Backpressure: lu channel is valid/ready (ready = FIFO not full); ex has none; starvation forces a 1-cycle stall_req.
module wb_write_arbiter #(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 5,
    parameter  int FIFO_DEPTH = 4,
    parameter  int STARVE_LIM = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1,
    localparam int SC_W       = $clog2(STARVE_LIM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              stall_req,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_pending,
    output logic [CNT_W-1:0]  fifo_count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [SC_W-1:0]   starve_cnt;

    logic              ex_take;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              blocked;
    logic              starve_hit;
    entry_t            head;

    // Per-cycle arbitration decisions; ex loses only while draining.
    always_comb begin
        fifo_empty = (count == '0);
        lu_ready   = (count < CNT_W'(FIFO_DEPTH));
        ex_take    = ex_valid && (ex_waddr != '0) && (state != ST_DRAIN);
        pop        = !ex_take && !fifo_empty;
        blocked    = ex_take && !fifo_empty;
        // Writes to register 0 still handshake but are dropped here.
        push       = lu_valid && lu_ready && (lu_waddr != '0);
        starve_hit = blocked && (starve_cnt == SC_W'(STARVE_LIM - 1));
        head       = mem[rd_ptr];
        fifo_count = count;
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers and occupancy; a reset discards all buffered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: lu_waddr, data: lu_wdata};
    end

    // Registered write port; address/data hold when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (ex_take) begin
            we    <= 1'b1;
            waddr <= ex_waddr;
            wdata <= ex_wdata;
        end else if (pop) begin
            we    <= 1'b1;
            waddr <= head.addr;
            wdata <= head.data;
        end else begin
            we    <= 1'b0;
        end
    end

    // Consecutive cycles the FIFO head lost to ex; any pop clears the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ST_DRAIN || pop) begin
            starve_cnt <= '0;
        end else if (blocked) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: track occupancy, force a one-cycle drain after a starvation run.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (count_nxt != '0) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (starve_hit)             state_nxt = ST_DRAIN;
                else if (count_nxt == '0)   state_nxt = ST_IDLE;
            end
            ST_DRAIN: state_nxt = (count_nxt != '0) ? ST_WAIT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: the pipeline is held for exactly the drain cycle.
    always_comb begin
        stall_req = (state == ST_DRAIN);
    end

    // Hazard query across live entries, including the head being issued now.
    always_comb begin
        logic [PTR_W-1:0] off;
        off         = '0;
        chk_pending = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ((chk_addr != '0) && ({1'b0, off} < count) && (mem[i].addr == chk_addr))
                chk_pending = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 4;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic [AW-1:0] ex_waddr = '0;
    logic [DW-1:0] ex_wdata = '0;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [AW-1:0] lu_waddr = '0;
    logic [DW-1:0] lu_wdata = '0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          stall_req;
    logic [AW-1:0] chk_addr = '0;
    logic          chk_pending;
    logic [2:0]    fifo_count;

    wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEP), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req),
        .chk_addr(chk_addr), .chk_pending(chk_pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int ev; int ea; int ed; int lv; int la; int ld; int ca;
        int we; int wa; int wd; int st; int cnt; int rdy; int pend;
    } vec_t;
    vec_t tbl[$];

    typedef struct { int addr; int data; } ent_t;
    ent_t mq[$];
    int   m_run;
    bit   m_drain;
    int   m_we, m_wa, m_wd;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ev, input int ea, input int ed,
                         input int lv, input int la, input int ld, input int ca);
        ex_valid = ev[0];
        ex_waddr = AW'(ea);
        ex_wdata = DW'(ed);
        lu_valid = lv[0];
        lu_waddr = AW'(la);
        lu_wdata = DW'(ld);
        chk_addr = AW'(ca);
    endtask

    function automatic void add(int ev, int ea, int ed, int lv, int la, int ld, int ca,
                                int we_e, int wa, int wd, int st, int cnt, int rdy, int pend);
        vec_t v;
        v = '{ev, ea, ed, lv, la, ld, ca, we_e, wa, wd, st, cnt, rdy, pend};
        tbl.push_back(v);
    endfunction

    // Reference: queue of buffered results; ex wins unless a drain is due.
    task automatic model_step(input int ev, input int ea, input int ed,
                              input int lv, input int la, input int ld);
        bit   rdy;
        bit   ex_wins;
        ent_t e;
        rdy     = (mq.size() < DEP);
        ex_wins = (ev != 0) && (ea != 0) && !m_drain;
        if (ex_wins) begin
            m_we = 1; m_wa = ea; m_wd = ed;
            if (mq.size() > 0) m_run++;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1; m_wa = e.addr; m_wd = e.data;
            m_run = 0;
        end else begin
            m_we = 0;
        end
        m_drain = ex_wins && (mq.size() > 0) && (m_run >= LIM);
        if (lv != 0 && rdy && la != 0) begin
            e.addr = la; e.data = ld;
            mq.push_back(e);
        end
    endtask

    function automatic int model_pending(int ca);
        if (ca == 0) return 0;
        foreach (mq[i]) if (mq[i].addr == ca) return 1;
        return 0;
    endfunction

    initial begin
        // Directed table: single write, fill to full, push/pop overlap, reg-0 drops, hazard query.
        add(1, 5, 'hA5,   0, 0, 0,     0,  1, 5,  'hA5,  0, 0, 1, 0);
        add(0, 0, 0,      0, 0, 0,     0,  0, 5,  'hA5,  0, 0, 1, 0);
        add(1, 20,'h200,  1, 1, 'h11,  0,  1, 20, 'h200, 0, 1, 1, 0);
        add(1, 20,'h201,  1, 2, 'h22,  0,  1, 20, 'h201, 0, 2, 1, 0);
        add(1, 20,'h202,  1, 3, 'h33,  0,  1, 20, 'h202, 0, 3, 1, 0);
        add(1, 20,'h203,  1, 4, 'h44,  3,  1, 20, 'h203, 0, 4, 0, 1);
        add(0, 0, 0,      1, 9, 'h99,  0,  1, 1,  'h11,  0, 3, 1, 0);
        add(0, 0, 0,      0, 0, 0,     1,  1, 2,  'h22,  0, 2, 1, 0);
        add(0, 0, 0,      1, 5, 'h55,  5,  1, 3,  'h33,  0, 2, 1, 1);
        add(1, 6, 'h66,   1, 0, 'h77,  0,  1, 6,  'h66,  0, 2, 1, 0);
        add(0, 0, 0,      0, 0, 0,     5,  1, 4,  'h44,  0, 1, 1, 1);
        add(0, 0, 0,      0, 0, 0,     5,  1, 5,  'h55,  0, 0, 1, 0);
        add(0, 0, 0,      0, 0, 0,     0,  0, 5,  'h55,  0, 0, 1, 0);
        add(0, 0, 0,      1, 9, 'h99,  9,  0, 5,  'h55,  0, 1, 1, 1);
        add(1, 8, 'h88,   0, 0, 0,     0,  1, 8,  'h88,  0, 1, 1, 0);
        add(0, 0, 0,      0, 0, 0,     9,  1, 9,  'h99,  0, 0, 1, 0);
        add(1, 0, 'hDEAD, 0, 0, 0,     0,  0, 9,  'h99,  0, 0, 1, 0);

        rst = 1'b1;
        #12;
        chk("reset_we", we, 0);
        chk("reset_waddr", waddr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_stall", stall_req, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", lu_ready, 1);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].ca);
            if (i == 9) begin
                #1;
                chk("tbl9_ready_reg0_handshake", lu_ready, 1);
            end
            tick();
            chk($sformatf("tbl%0d_we", i),    we,          tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), waddr,       tbl[i].wa);
            chk($sformatf("tbl%0d_wdata", i), wdata,       tbl[i].wd);
            chk($sformatf("tbl%0d_stall", i), stall_req,   tbl[i].st);
            chk($sformatf("tbl%0d_count", i), fifo_count,  tbl[i].cnt);
            chk($sformatf("tbl%0d_ready", i), lu_ready,    tbl[i].rdy);
            chk($sformatf("tbl%0d_pend", i),  chk_pending, tbl[i].pend);
        end

        // Starvation: ex held on addr 7 with one buffered entry; one drain cycle after LIM losses.
        for (int k = 0; k < 7; k++) begin
            drive(1, 7, 'h700 + k, (k == 0) ? 1 : 0, 10, 'hAB, 0);
            tick();
            chk($sformatf("starve%0d_stall", k), stall_req, (k == LIM) ? 1 : 0);
            chk($sformatf("starve%0d_waddr", k), waddr, (k == LIM + 1) ? 10 : 7);
            chk($sformatf("starve%0d_wdata", k), wdata, (k == LIM + 1) ? 'hAB : 'h700 + k);
            chk($sformatf("starve%0d_count", k), fifo_count, (k <= LIM) ? 1 : 0);
        end

        // Reset mid-drain with three buffered entries.
        for (int k = 0; k < LIM + 1; k++) begin
            drive(1, 7, 'h800 + k, (k < 3) ? 1 : 0, 11 + k, 'h900 + k, 0);
            tick();
        end
        chk("pre_rst_stall", stall_req, 1);
        chk("pre_rst_count", fifo_count, 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", we, 0);
        chk("async_rst_waddr", waddr, 0);
        chk("async_rst_wdata", wdata, 0);
        chk("async_rst_stall", stall_req, 0);
        chk("async_rst_count", fifo_count, 0);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst%0d_we", k), we, 0);
            chk($sformatf("post_rst%0d_count", k), fifo_count, 0);
        end

        // Randomized traffic against the queue model.
        mq.delete();
        m_run = 0; m_drain = 0; m_we = 0; m_wa = 0; m_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            int ev, ea, ed, lv, la, ld, ca;
            ev = ($urandom_range(0, 99) < 65) ? 1 : 0;
            ea = $urandom_range(0, 7);
            ed = int'($urandom());
            lv = ($urandom_range(0, 99) < 55) ? 1 : 0;
            la = $urandom_range(0, 7);
            ld = int'($urandom());
            ca = $urandom_range(0, 7);
            drive(ev, ea, ed, lv, la, ld, ca);
            #1;
            chk($sformatf("rnd%0d_ready", c), lu_ready, (mq.size() < DEP) ? 1 : 0);
            chk($sformatf("rnd%0d_pend", c), chk_pending, model_pending(ca));
            chk($sformatf("rnd%0d_count", c), fifo_count, mq.size());
            model_step(ev, ea, ed, lv, la, ld);
            tick();
            chk($sformatf("rnd%0d_we", c), we, m_we);
            chk($sformatf("rnd%0d_waddr", c), waddr, m_wa);
            chk($sformatf("rnd%0d_wdata", c), wdata, m_wd);
            chk($sformatf("rnd%0d_stall", c), stall_req, m_drain ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
